stopwatch_core: RTL and testbench

Parametrised BCD stopwatch/timer core: divides the system clock to a count tick, runs a mixed-radix digit chain (hundredths up to tens of minutes), and supports up-count, preset count-down with expiry, and lap-hold display. It sits between the debounced button pulses and the seven-segment display multiplexer in the Basys3 stopwatch design, replacing the fixed 4-digit up-counter.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_core_if.sv | 27 ++
 rtl/tick_gen.sv | 29 ++
 rtl/stopwatch_core.sv | 146 ++++++++++++++
 tb/tb_stopwatch_core.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM states, BCD digit
// type and the per-digit radix table (hundredths up to tens of minutes).
package stopwatch_pkg;

    localparam int MAX_DIGITS = 6;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Digit 0 is hundredths; digits 3 and 5 are the tens-of-seconds and
    // tens-of-minutes positions, hence radix 6.
    localparam int RADIX [MAX_DIGITS] = '{10, 10, 10, 6, 10, 6};

    function automatic bcd_t digit_max(input int k);
        return bcd_t'(RADIX[k] - 1);
    endfunction

    // Out-of-range preset digits clamp to the largest legal value.
    function automatic bcd_t saturate(input bcd_t v, input int k);
        return (int'(v) > RADIX[k] - 1) ? digit_max(k) : v;
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control pulses, preset and display/status signals between the button
// front end (master) and the stopwatch core (slave).
interface stopwatch_core_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    start_stop;
    logic                    clear;
    logic                    lap;
    logic                    count_down;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] preset;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    running;
    logic                    lap_active;
    logic                    expired;
    logic                    wrapped;

    modport master (
        output start_stop, clear, lap, count_down, load, preset,
        input  digits, running, lap_active, expired, wrapped
    );

    modport slave (
        input  start_stop, clear, lap, count_down, load, preset,
        output digits, running, lap_active, expired, wrapped
    );
endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, holds while disabled so a
// paused stopwatch resumes with its sub-tick phase intact.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // Prescaler register: clear and reset both return to phase zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && !clear && (count == LAST);
endmodule

// File: rtl/stopwatch_core.sv
// BCD stopwatch/timer core with up-count, preset count-down with expiry
// and lap-hold display.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | stopped after reset/clear, prescaler at zero
//   ST_RUN     | prescaler running, digits advance on each tick
//   ST_PAUSED  | count and prescaler phase held
//   ST_EXPIRED | count-down hit zero; only clear/reset leave
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 100,
    parameter int NUM_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_core_if.slave  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int W   = 4 * NUM_DIGITS;

    state_t         state, state_next;
    logic           mode, mode_next;
    logic           lap_q, lap_next;
    logic [W-1:0]   live, live_next;
    logic [W-1:0]   snap, snap_next;
    logic [W-1:0]   up_val, dn_val, preset_sat;
    logic [NUM_DIGITS:0] carry, borrow;
    logic           tick, load_ok, ev_load, ev_ss, ev_lap, idle_or_paused;
    logic           wrap_now, expire_now, live_zero;
    logic           running_d, expired_d, wrapped_d;
    logic [W-1:0]   digits_d;

    // Pulse priority: clear > load > start_stop > lap.
    assign ev_load        = bus.load && !bus.clear;
    assign ev_ss          = bus.start_stop && !bus.clear && !bus.load;
    assign ev_lap         = bus.lap && !bus.clear && !bus.load && !bus.start_stop;
    assign idle_or_paused = (state == ST_IDLE) || (state == ST_PAUSED);
    assign load_ok        = ev_load && idle_or_paused;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (state == ST_RUN),
        .clear  (bus.clear),
        .tick   (tick)
    );

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_t d;
        logic at_max, at_zero;
        assign d       = live[4*k +: 4];
        assign at_max  = (d == digit_max(k));
        assign at_zero = (d == 4'd0);
        assign up_val[4*k +: 4] = carry[k]  ? (at_max  ? 4'd0 : d + 4'd1) : d;
        assign dn_val[4*k +: 4] = borrow[k] ? (at_zero ? digit_max(k) : d - 4'd1) : d;
        assign carry[k+1]  = carry[k]  && at_max;
        assign borrow[k+1] = borrow[k] && at_zero;
        assign preset_sat[4*k +: 4] = saturate(bus.preset[4*k +: 4], k);
    end

    assign live_zero  = (live == '0);
    assign wrap_now   = tick && !mode && carry[NUM_DIGITS];
    assign expire_now = tick && mode && (dn_val == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; expiry outranks a same-cycle start_stop.
    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = ST_IDLE;
        end else if (expire_now) begin
            state_next = ST_EXPIRED;
        end else if (ev_ss) begin
            case (state)
                ST_IDLE, ST_PAUSED:
                    state_next = (bus.count_down && live_zero) ? ST_EXPIRED : ST_RUN;
                ST_RUN:  state_next = ST_PAUSED;
                default: state_next = state;
            endcase
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        running_d = (state_next == ST_RUN);
        expired_d = (state_next == ST_EXPIRED);
        wrapped_d = wrap_now && !bus.clear;
        digits_d  = lap_next ? snap_next : live_next;
    end

    // Counter, mode latch and lap snapshot next values.
    always_comb begin
        live_next = live;
        snap_next = snap;
        lap_next  = lap_q;
        mode_next = mode;
        if (bus.clear) begin
            live_next = '0;
            lap_next  = 1'b0;
        end else begin
            if (load_ok)   live_next = preset_sat;
            else if (tick) live_next = mode ? dn_val : up_val;
            if (ev_ss && idle_or_paused) mode_next = bus.count_down;
            if (ev_lap && (state == ST_RUN || state == ST_PAUSED)) begin
                lap_next = !lap_q;
                if (!lap_q) snap_next = live;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            live           <= '0;
            snap           <= '0;
            lap_q          <= 1'b0;
            mode           <= 1'b0;
            bus.digits     <= '0;
            bus.running    <= 1'b0;
            bus.lap_active <= 1'b0;
            bus.expired    <= 1'b0;
            bus.wrapped    <= 1'b0;
        end else begin
            live           <= live_next;
            snap           <= snap_next;
            lap_q          <= lap_next;
            mode           <= mode_next;
            bus.digits     <= digits_d;
            bus.running    <= running_d;
            bus.lap_active <= lap_next;
            bus.expired    <= expired_d;
            bus.wrapped    <= wrapped_d;
        end
    end
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus randomized pulses,
// every cycle compared against an integer-valued reference model.
module tb_stopwatch_core;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int ND      = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic clk = 1'b0;
    logic reset;

    stopwatch_core_if #(.NUM_DIGITS(ND)) bus ();

    stopwatch_core #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_DIGITS(ND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int radix [6] = '{10, 10, 10, 6, 10, 6};
    int checks = 0;
    int failures = 0;
    int modulus;
    int m_state, m_val, m_mode, m_pre, m_lap, m_snap, m_wrapped;

    function automatic int bcd_to_int(input logic [4*ND-1:0] b, input bit sat);
        int v, w, d;
        v = 0;
        w = 1;
        for (int k = 0; k < ND; k++) begin
            d = int'(b[4*k +: 4]);
            if (sat && d > radix[k] - 1) d = radix[k] - 1;
            v += d * w;
            w *= radix[k];
        end
        return v;
    endfunction

    function automatic logic [4*ND-1:0] int_to_bcd(input int v);
        logic [4*ND-1:0] r;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(v % radix[k]);
            v = v / radix[k];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the count is one integer modulo the chain capacity.
    task automatic model_edge();
        int  old_val, old_state;
        bit  tick, expire;
        if (!reset) begin
            m_state = M_IDLE; m_val = 0; m_mode = 0; m_pre = 0;
            m_lap = 0; m_snap = 0; m_wrapped = 0;
            return;
        end
        old_val   = m_val;
        old_state = m_state;
        tick      = (m_state == M_RUN) && (m_pre == DIV - 1);
        expire    = 0;
        m_wrapped = 0;
        if (bus.clear) m_pre = 0;
        else if (m_state == M_RUN) m_pre = (m_pre + 1) % DIV;
        if (bus.clear) begin
            m_state = M_IDLE;
            m_val   = 0;
            m_lap   = 0;
            return;
        end
        if (tick) begin
            if (m_mode == 0) begin
                m_wrapped = (m_val == modulus - 1);
                m_val = (m_val + 1) % modulus;
            end else begin
                m_val = (m_val + modulus - 1) % modulus;
                expire = (m_val == 0);
            end
        end
        if (bus.load && (old_state == M_IDLE || old_state == M_PAUSED))
            m_val = bcd_to_int(bus.preset, 1'b1);
        if (expire) begin
            m_state = M_EXP;
        end else if (bus.start_stop && !bus.load) begin
            if (old_state == M_IDLE || old_state == M_PAUSED) begin
                m_mode  = int'(bus.count_down);
                m_state = (bus.count_down && old_val == 0) ? M_EXP : M_RUN;
            end else if (old_state == M_RUN) begin
                m_state = M_PAUSED;
            end
        end
        if (bus.lap && !bus.load && !bus.start_stop &&
            (old_state == M_RUN || old_state == M_PAUSED)) begin
            if (m_lap == 0) m_snap = old_val;
            m_lap = (m_lap == 0) ? 1 : 0;
        end
    endtask

    task automatic step(input bit ss, input bit cl, input bit lp, input bit ld, input bit rs_n);
        logic [31:0] got, exp;
        bus.start_stop = ss;
        bus.clear      = cl;
        bus.lap        = lp;
        bus.load       = ld;
        reset          = rs_n;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        got = {12'd0, bus.running, bus.lap_active, bus.expired, bus.wrapped, bus.digits};
        exp = {12'd0, m_state == M_RUN, m_lap != 0, m_state == M_EXP, m_wrapped != 0,
               int_to_bcd((m_lap != 0) ? m_snap : m_val)};
        check("cycle", got, exp);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        modulus = 1;
        for (int k = 0; k < ND; k++) modulus *= radix[k];
        bus.start_stop = 0; bus.clear = 0; bus.lap = 0; bus.load = 0;
        bus.count_down = 0; bus.preset = '0; reset = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("reset_state", {bus.running, bus.lap_active, bus.expired, bus.wrapped, bus.digits}, 0);

        // 1.00 s of up-count
        step(1, 0, 0, 0, 1);
        check("running_rise", bus.running, 1);
        idle_steps(9);
        check("before_first_tick", bus.digits, 16'h0000);
        idle_steps(1);
        check("first_tick", bus.digits, 16'h0001);
        idle_steps(990);
        check("one_second", bus.digits, 16'h0100);

        // rollover from the maximum
        step(0, 1, 0, 0, 1);
        bus.preset = 16'h5999;
        step(0, 0, 0, 1, 1);
        check("load_max", bus.digits, 16'h5999);
        step(1, 0, 0, 0, 1);
        idle_steps(10);
        check("wrap_digits", bus.digits, 16'h0000);
        check("wrap_pulse", bus.wrapped, 1);
        check("wrap_running", bus.running, 1);
        idle_steps(1);
        check("wrap_one_cycle", bus.wrapped, 0);

        // count-down expiry
        step(0, 1, 0, 0, 1);
        bus.count_down = 1;
        bus.preset = 16'h0003;
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1);
        idle_steps(29);
        check("down_before_zero", {bus.expired, bus.digits}, 17'h00001);
        idle_steps(1);
        check("down_expired", {bus.running, bus.expired, bus.digits}, 18'h10000);
        step(1, 0, 0, 0, 1);
        check("expired_ignores_start", {bus.running, bus.expired}, 2'b01);
        step(0, 1, 0, 0, 1);
        check("clear_expired", {bus.running, bus.expired, bus.digits}, 18'h00000);
        step(1, 0, 0, 0, 1);
        check("down_zero_start", {bus.running, bus.expired}, 2'b01);

        // pause keeps the sub-tick phase
        step(0, 1, 0, 0, 1);
        bus.count_down = 0;
        step(1, 0, 0, 0, 1);
        idle_steps(25);
        step(1, 0, 0, 0, 1);
        idle_steps(37);
        check("paused_hold", {bus.running, bus.digits}, 17'h00002);
        step(1, 0, 0, 0, 1);
        idle_steps(3);
        check("resume_pre_tick", bus.digits, 16'h0002);
        idle_steps(1);
        check("phase_kept", bus.digits, 16'h0003);

        // lap hold
        step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        idle_steps(420);
        check("at_042", bus.digits, 16'h0042);
        step(0, 0, 1, 0, 1);
        check("lap_set", bus.lap_active, 1);
        idle_steps(579);
        check("lap_hold", bus.digits, 16'h0042);
        step(0, 0, 1, 0, 1);
        check("lap_release", {bus.lap_active, bus.digits}, 17'h00100);

        // clear beats start_stop; reset mid-count; preset saturation
        step(1, 1, 0, 0, 1);
        check("clear_over_start", {bus.running, bus.digits}, 17'h00000);
        step(1, 0, 0, 0, 1);
        idle_steps(55);
        step(0, 0, 0, 0, 0);
        check("reset_mid_count", {bus.running, bus.digits}, 17'h00000);
        bus.preset = 16'h9977;
        step(0, 0, 0, 1, 1);
        check("preset_saturate", bus.digits, 16'h5977);

        // randomized pulses against the model
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 99) == 0) bus.count_down = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 0) bus.preset = 16'($urandom_range(0, 15));
                else                           bus.preset = 16'($urandom);
            end
            step($urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 99) == 0,
                 !($urandom_range(0, 2999) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
